// File: rtl/control_unit.sv
// Instruction decoder: combinational decode of opcode into a registered control word.
// Optional macro CU_COND_JUMP_EN adds carry/zero flag inputs and the JC/JZ instructions.
module control_unit (
   input  logic       in_clk,
   input  logic       in_reset,
   input  logic [7:0] opcode,
`ifdef CU_COND_JUMP_EN
   input  logic       carry_CU,
   input  logic       zero_CU,
`endif
   output logic [2:0] f_CU,
   output logic [1:0] B_sel_CU,
   output logic       write_a_CU,
   output logic       write_b_CU,
   output logic       write_o_CU,
   output logic       write_cz_CU,
   output logic       PC_sel_CU,
   output logic       write_pc_CU
);

   typedef struct packed {
      logic [2:0] f;
      logic [1:0] b_sel;
      logic       write_a;
      logic       write_b;
      logic       write_o;
      logic       write_cz;
      logic       pc_sel;
      logic       write_pc;
   } ctrl_t;

   localparam ctrl_t NOP_WORD = '0;

   ctrl_t decoded;
   ctrl_t ctrl_q;

   always_comb begin
      decoded = NOP_WORD;
      case (opcode[7:4])
         4'b0100: begin
            decoded.b_sel    = 2'b01;
            decoded.write_a  = 1'b1;
            decoded.write_cz = 1'b1;
            decoded.write_pc = 1'b1;
         end
         4'b0101: begin
            if (opcode[3:0] == 4'b0000) begin
               decoded.b_sel    = 2'b11;
               decoded.write_a  = 1'b1;
               decoded.write_cz = 1'b1;
               decoded.write_pc = 1'b1;
            end else if (opcode[3:0] == 4'b0001) begin
               decoded.write_o  = 1'b1;
               decoded.write_cz = 1'b1;
               decoded.write_pc = 1'b1;
            end
         end
         4'b0110: begin
            if (opcode[3:0] == 4'b0000) begin
               decoded.f        = 3'b001;
               decoded.write_b  = 1'b1;
               decoded.write_cz = 1'b1;
               decoded.write_pc = 1'b1;
            end
         end
         4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
            // ALU ops 1000..1101 map to f = 010..111, i.e. low three opcode bits plus two
            decoded.f        = opcode[6:4] + 3'd2;
            decoded.write_a  = 1'b1;
            decoded.write_cz = 1'b1;
            decoded.write_pc = 1'b1;
         end
         4'b1001: begin
            decoded.f        = 3'b011;
            decoded.write_b  = 1'b1;
            decoded.write_cz = 1'b1;
            decoded.write_pc = 1'b1;
         end
         4'b1110: begin
            decoded.pc_sel   = 1'b1;
            decoded.write_pc = 1'b1;
         end
`ifdef CU_COND_JUMP_EN
         4'b1111: begin
            if (opcode[3:0] == 4'b0000) begin
               decoded.pc_sel   = carry_CU;
               decoded.write_pc = 1'b1;
            end else if (opcode[3:0] == 4'b0001) begin
               decoded.pc_sel   = zero_CU;
               decoded.write_pc = 1'b1;
            end
         end
`endif
         default: decoded = NOP_WORD;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         ctrl_q <= NOP_WORD;
      end else begin
         ctrl_q <= decoded;
      end
   end

   assign f_CU        = ctrl_q.f;
   assign B_sel_CU    = ctrl_q.b_sel;
   assign write_a_CU  = ctrl_q.write_a;
   assign write_b_CU  = ctrl_q.write_b;
   assign write_o_CU  = ctrl_q.write_o;
   assign write_cz_CU = ctrl_q.write_cz;
   assign PC_sel_CU   = ctrl_q.pc_sel;
   assign write_pc_CU = ctrl_q.write_pc;

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit; control word packed as
// {f[2:0], B_sel[1:0], write_a, write_b, write_o, write_cz, PC_sel, write_pc}.
module tb_control_unit;

   logic       in_clk = 1'b0;
   logic       in_reset;
   logic [7:0] opcode;
   logic       carry_CU;
   logic       zero_CU;
   logic [2:0] f_CU;
   logic [1:0] B_sel_CU;
   logic       write_a_CU;
   logic       write_b_CU;
   logic       write_o_CU;
   logic       write_cz_CU;
   logic       PC_sel_CU;
   logic       write_pc_CU;

   int compared   = 0;
   int mismatched = 0;

   always #5 in_clk = ~in_clk;

   control_unit dut (
      .in_clk      (in_clk),
      .in_reset    (in_reset),
      .opcode      (opcode),
`ifdef CU_COND_JUMP_EN
      .carry_CU    (carry_CU),
      .zero_CU     (zero_CU),
`endif
      .f_CU        (f_CU),
      .B_sel_CU    (B_sel_CU),
      .write_a_CU  (write_a_CU),
      .write_b_CU  (write_b_CU),
      .write_o_CU  (write_o_CU),
      .write_cz_CU (write_cz_CU),
      .PC_sel_CU   (PC_sel_CU),
      .write_pc_CU (write_pc_CU)
   );

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic        carry;
      logic        zero;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [10:0] mk(input logic [2:0] f, input logic [1:0] bsel,
                                      input logic wa, input logic wb, input logic wo,
                                      input logic wcz, input logic pcsel, input logic wpc);
      return {f, bsel, wa, wb, wo, wcz, pcsel, wpc};
   endfunction

   function automatic logic [10:0] actual();
      return {f_CU, B_sel_CU, write_a_CU, write_b_CU, write_o_CU,
              write_cz_CU, PC_sel_CU, write_pc_CU};
   endfunction

   task automatic check(input string name, input logic [10:0] exp);
      logic [10:0] act;
      act = actual();
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [7:0] op, input logic c,
                      input logic z, input logic [10:0] exp);
      vec_t v;
      v.name = name; v.op = op; v.carry = c; v.zero = z; v.exp = exp;
      vecs.push_back(v);
   endtask

   localparam logic [10:0] NOP = 11'b0;

   initial begin
      in_reset = 1'b1;
      opcode   = 8'hA0;
      carry_CU = 1'b0;
      zero_CU  = 1'b0;

      add("nop",      8'b0000_0000, 0, 0, NOP);
      add("a_imm",    8'b0100_0001, 0, 0, mk(3'b000, 2'b01, 1, 0, 0, 1, 0, 1));
      add("a_in",     8'b0101_0000, 0, 0, mk(3'b000, 2'b11, 1, 0, 0, 1, 0, 1));
      add("out_a",    8'b0101_0001, 0, 0, mk(3'b000, 2'b00, 0, 0, 1, 1, 0, 1));
      add("b_a",      8'b0110_0000, 0, 0, mk(3'b001, 2'b00, 0, 1, 0, 1, 0, 1));
      add("inc_a",    8'b1000_0011, 0, 0, mk(3'b010, 2'b00, 1, 0, 0, 1, 0, 1));
      add("inc_b",    8'b1001_1111, 0, 0, mk(3'b011, 2'b00, 0, 1, 0, 1, 0, 1));
      add("add",      8'b1010_0101, 0, 0, mk(3'b100, 2'b00, 1, 0, 0, 1, 0, 1));
      add("sub",      8'b1011_0000, 0, 0, mk(3'b101, 2'b00, 1, 0, 0, 1, 0, 1));
      add("and",      8'b1100_1010, 0, 0, mk(3'b110, 2'b00, 1, 0, 0, 1, 0, 1));
      add("or",       8'b1101_0001, 0, 0, mk(3'b111, 2'b00, 1, 0, 0, 1, 0, 1));
      add("undef_3",  8'b0011_0101, 0, 0, NOP);
      add("undef_52", 8'b0101_0010, 0, 0, NOP);
      add("undef_7",  8'b0111_0000, 0, 0, NOP);
      add("undef_68", 8'b0110_1000, 0, 0, NOP);
      add("undef_1",  8'b0001_1111, 0, 0, NOP);
      add("undef_2",  8'b0010_0001, 0, 0, NOP);
      add("jmp",      8'b1110_0000, 0, 0, mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 1));
      add("jmp_f",    8'b1110_1111, 1, 1, mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 1));
`ifdef CU_COND_JUMP_EN
      add("jc_c0",    8'b1111_0000, 0, 1, mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 1));
      add("jc_c1",    8'b1111_0000, 1, 0, mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 1));
      add("jz_z1",    8'b1111_0001, 0, 1, mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 1));
      add("jz_z0",    8'b1111_0001, 1, 0, mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 1));
      add("f_other",  8'b1111_0010, 1, 1, NOP);
`else
      add("f0_nop",   8'b1111_0000, 1, 1, NOP);
      add("f1_nop",   8'b1111_0001, 1, 1, NOP);
`endif

      // Reset asserted at time zero: NOP before any edge, and held across edges
      #1;
      check("reset_now", NOP);
      @(posedge in_clk); #1;
      check("reset_held", NOP);

      // First edge after release captures the add opcode
      @(negedge in_clk);
      in_reset = 1'b0;
      #1;
      check("release_pre_edge", NOP);
      @(posedge in_clk); #1;
      check("release_add", mk(3'b100, 2'b00, 1, 0, 0, 1, 0, 1));

      // Asynchronous reset mid-cycle clears immediately
      #2;
      in_reset = 1'b1;
      #1;
      check("async_reset", NOP);
      @(negedge in_clk);
      in_reset = 1'b0;
      opcode   = 8'h40;
      @(posedge in_clk); #1;
      check("after_reset_imm", mk(3'b000, 2'b01, 1, 0, 0, 1, 0, 1));

      foreach (vecs[i]) begin
         @(negedge in_clk);
         opcode   = vecs[i].op;
         carry_CU = vecs[i].carry;
         zero_CU  = vecs[i].zero;
         @(posedge in_clk); #1;
         check({vecs[i].name, "_c1"}, vecs[i].exp);
         @(posedge in_clk); #1;
         check({vecs[i].name, "_c2"}, vecs[i].exp);
      end

      // One-edge latency: a new opcode does not appear before the edge
      @(negedge in_clk);
      opcode = 8'hA0;
      @(posedge in_clk); #1;
      @(negedge in_clk);
      opcode = 8'h90;
      #1;
      check("latency_hold", mk(3'b100, 2'b00, 1, 0, 0, 1, 0, 1));
      @(posedge in_clk); #1;
      check("latency_load", mk(3'b011, 2'b00, 0, 1, 0, 1, 0, 1));

      // Only the opcode present at the edge matters
      @(negedge in_clk);
      opcode = 8'h00;
      #1 opcode = 8'hC0;
      #1 opcode = 8'h51;
      @(posedge in_clk); #1;
      check("last_value_wins", mk(3'b000, 2'b00, 0, 0, 1, 1, 0, 1));

`ifdef CU_COND_JUMP_EN
      // Flag sampled at the edge, not before
      @(negedge in_clk);
      opcode   = 8'hF0;
      carry_CU = 1'b0;
      #2 carry_CU = 1'b1;
      @(posedge in_clk); #1;
      carry_CU = 1'b0;
      #1;
      check("jc_edge_sample", mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
